// File: rtl/cpu_pkg.sv
// Shared constants and control-field layouts for the 5-stage 64-bit ARM-subset CPU.
package cpu_pkg;

    localparam int DATA_W  = 64;
    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;

    typedef struct packed {
        logic       flagen;
        logic       shiftdir;
        logic       alusrc;
        logic [2:0] aluop;
    } ex_ctrl_t;

    typedef struct packed {
        logic brsel;
        logic branch;
        logic ubranch;
        logic memwrite;
        logic memread;
    } m_ctrl_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

    localparam int EX_W = $bits(ex_ctrl_t);
    localparam int M_W  = $bits(m_ctrl_t);
    localparam int WB_W = $bits(wb_ctrl_t);

    localparam int IFID_W  = INSTR_W + DATA_W;
    localparam int IDEX_W  = 4 * DATA_W + 3 * REG_W + EX_W + M_W + WB_W;
    localparam int EXMEM_W = 3 * DATA_W + REG_W + WB_W + M_W + 8;

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register: async clear, synchronous flush-to-zero, load enable.
// Latency: 1 cycle from d to q when en=1.
// Backpressure: en=0 holds q; flush overrides en and inserts a zero bubble.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// IF/ID, ID/EX and EX/MEM forward pipeline banks, each with independent stall and flush.
// Latency: 1 cycle per bank; outputs come straight from flops.
// Backpressure: per-bank en=0 holds contents; flush zeroes the bank (bubble), winning over en.
module pipe_stage_regs
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,

    input  logic               ifid_en,
    input  logic               ifid_flush,
    input  logic               idex_en,
    input  logic               idex_flush,
    input  logic               exmem_en,
    input  logic               exmem_flush,

    input  logic [INSTR_W-1:0] ifid_instr,
    input  logic [DATA_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr_out,
    output logic [DATA_W-1:0]  ifid_pc_out,

    input  logic [DATA_W-1:0]  idex_rd1,
    input  logic [DATA_W-1:0]  idex_rd2,
    input  logic [DATA_W-1:0]  idex_pc,
    input  logic [DATA_W-1:0]  idex_se,
    input  logic [REG_W-1:0]   idex_rn,
    input  logic [REG_W-1:0]   idex_rm,
    input  logic [REG_W-1:0]   idex_rd,
    input  ex_ctrl_t           idex_ex,
    input  m_ctrl_t            idex_m,
    input  wb_ctrl_t           idex_wb,
    output logic [DATA_W-1:0]  idex_rd1_out,
    output logic [DATA_W-1:0]  idex_rd2_out,
    output logic [DATA_W-1:0]  idex_pc_out,
    output logic [DATA_W-1:0]  idex_se_out,
    output logic [REG_W-1:0]   idex_rn_out,
    output logic [REG_W-1:0]   idex_rm_out,
    output logic [REG_W-1:0]   idex_rd_out,
    output ex_ctrl_t           idex_ex_out,
    output m_ctrl_t            idex_m_out,
    output wb_ctrl_t           idex_wb_out,

    input  logic [DATA_W-1:0]  exmem_alu,
    input  logic [DATA_W-1:0]  exmem_wdata,
    input  logic [DATA_W-1:0]  exmem_addr,
    input  logic [REG_W-1:0]   exmem_rd,
    input  wb_ctrl_t           exmem_wb,
    input  m_ctrl_t            exmem_m,
    input  logic               exmem_z_alu,
    input  logic               exmem_n_alu,
    input  logic               exmem_v_alu,
    input  logic               exmem_c_alu,
    input  logic               exmem_z_flag,
    input  logic               exmem_n_flag,
    input  logic               exmem_v_flag,
    input  logic               exmem_c_flag,
    output logic [DATA_W-1:0]  exmem_alu_out,
    output logic [DATA_W-1:0]  exmem_wdata_out,
    output logic [DATA_W-1:0]  exmem_addr_out,
    output logic [REG_W-1:0]   exmem_rd_out,
    output wb_ctrl_t           exmem_wb_out,
    output m_ctrl_t            exmem_m_out,
    output logic               exmem_z_alu_out,
    output logic               exmem_n_alu_out,
    output logic               exmem_v_alu_out,
    output logic               exmem_c_alu_out,
    output logic               exmem_z_flag_out,
    output logic               exmem_n_flag_out,
    output logic               exmem_v_flag_out,
    output logic               exmem_c_flag_out
);

    logic [IFID_W-1:0]  ifid_q;
    logic [IDEX_W-1:0]  idex_q;
    logic [EXMEM_W-1:0] exmem_q;

    // Each bank is one flat register; flush clears data and control alike.
    pipe_reg #(.W(IFID_W)) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .en    (ifid_en),
        .flush (ifid_flush),
        .d     ({ifid_instr, ifid_pc}),
        .q     (ifid_q)
    );

    pipe_reg #(.W(IDEX_W)) u_idex (
        .clk   (clk),
        .rst   (rst),
        .en    (idex_en),
        .flush (idex_flush),
        .d     ({idex_rd1, idex_rd2, idex_pc, idex_se,
                 idex_rn, idex_rm, idex_rd,
                 idex_ex, idex_m, idex_wb}),
        .q     (idex_q)
    );

    pipe_reg #(.W(EXMEM_W)) u_exmem (
        .clk   (clk),
        .rst   (rst),
        .en    (exmem_en),
        .flush (exmem_flush),
        .d     ({exmem_alu, exmem_wdata, exmem_addr, exmem_rd,
                 exmem_wb, exmem_m,
                 exmem_z_alu, exmem_n_alu, exmem_v_alu, exmem_c_alu,
                 exmem_z_flag, exmem_n_flag, exmem_v_flag, exmem_c_flag}),
        .q     (exmem_q)
    );

    assign {ifid_instr_out, ifid_pc_out} = ifid_q;

    assign {idex_rd1_out, idex_rd2_out, idex_pc_out, idex_se_out,
            idex_rn_out, idex_rm_out, idex_rd_out,
            idex_ex_out, idex_m_out, idex_wb_out} = idex_q;

    assign {exmem_alu_out, exmem_wdata_out, exmem_addr_out, exmem_rd_out,
            exmem_wb_out, exmem_m_out,
            exmem_z_alu_out, exmem_n_alu_out, exmem_v_alu_out, exmem_c_alu_out,
            exmem_z_flag_out, exmem_n_flag_out, exmem_v_flag_out, exmem_c_flag_out} = exmem_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed scoreboard bench for pipe_stage_regs: reset, pass-through, stall, flush, flags.
module tb_pipe_stage_regs;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;

    logic [INSTR_W-1:0] ifid_instr, ifid_instr_out;
    logic [DATA_W-1:0]  ifid_pc, ifid_pc_out;
    logic [DATA_W-1:0]  idex_rd1, idex_rd2, idex_pc, idex_se;
    logic [DATA_W-1:0]  idex_rd1_out, idex_rd2_out, idex_pc_out, idex_se_out;
    logic [REG_W-1:0]   idex_rn, idex_rm, idex_rd, idex_rn_out, idex_rm_out, idex_rd_out;
    ex_ctrl_t           idex_ex, idex_ex_out;
    m_ctrl_t            idex_m, idex_m_out;
    wb_ctrl_t           idex_wb, idex_wb_out;
    logic [DATA_W-1:0]  exmem_alu, exmem_wdata, exmem_addr;
    logic [DATA_W-1:0]  exmem_alu_out, exmem_wdata_out, exmem_addr_out;
    logic [REG_W-1:0]   exmem_rd, exmem_rd_out;
    wb_ctrl_t           exmem_wb, exmem_wb_out;
    m_ctrl_t            exmem_m, exmem_m_out;
    logic exmem_z_alu, exmem_n_alu, exmem_v_alu, exmem_c_alu;
    logic exmem_z_flag, exmem_n_flag, exmem_v_flag, exmem_c_flag;
    logic exmem_z_alu_out, exmem_n_alu_out, exmem_v_alu_out, exmem_c_alu_out;
    logic exmem_z_flag_out, exmem_n_flag_out, exmem_v_flag_out, exmem_c_flag_out;

    localparam int NSEL = 26;
    localparam int S_IFID_INSTR = 0, S_IFID_PC = 1, S_IDEX_RD1 = 2, S_IDEX_PC = 4;
    localparam int S_IDEX_RD = 8, S_IDEX_EX = 9, S_IDEX_M = 10, S_IDEX_WB = 11;
    localparam int S_EXMEM_ALU = 12, S_EXMEM_RD = 15, S_EXMEM_WB = 16, S_EXMEM_M = 17;
    localparam int S_Z_ALU = 18, S_V_FLAG = 24, S_N_FLAG = 23;

    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_regs dut (
        .clk(clk), .rst(rst),
        .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .exmem_flush(exmem_flush),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
        .ifid_instr_out(ifid_instr_out), .ifid_pc_out(ifid_pc_out),
        .idex_rd1(idex_rd1), .idex_rd2(idex_rd2), .idex_pc(idex_pc), .idex_se(idex_se),
        .idex_rn(idex_rn), .idex_rm(idex_rm), .idex_rd(idex_rd),
        .idex_ex(idex_ex), .idex_m(idex_m), .idex_wb(idex_wb),
        .idex_rd1_out(idex_rd1_out), .idex_rd2_out(idex_rd2_out),
        .idex_pc_out(idex_pc_out), .idex_se_out(idex_se_out),
        .idex_rn_out(idex_rn_out), .idex_rm_out(idex_rm_out), .idex_rd_out(idex_rd_out),
        .idex_ex_out(idex_ex_out), .idex_m_out(idex_m_out), .idex_wb_out(idex_wb_out),
        .exmem_alu(exmem_alu), .exmem_wdata(exmem_wdata), .exmem_addr(exmem_addr),
        .exmem_rd(exmem_rd), .exmem_wb(exmem_wb), .exmem_m(exmem_m),
        .exmem_z_alu(exmem_z_alu), .exmem_n_alu(exmem_n_alu),
        .exmem_v_alu(exmem_v_alu), .exmem_c_alu(exmem_c_alu),
        .exmem_z_flag(exmem_z_flag), .exmem_n_flag(exmem_n_flag),
        .exmem_v_flag(exmem_v_flag), .exmem_c_flag(exmem_c_flag),
        .exmem_alu_out(exmem_alu_out), .exmem_wdata_out(exmem_wdata_out),
        .exmem_addr_out(exmem_addr_out), .exmem_rd_out(exmem_rd_out),
        .exmem_wb_out(exmem_wb_out), .exmem_m_out(exmem_m_out),
        .exmem_z_alu_out(exmem_z_alu_out), .exmem_n_alu_out(exmem_n_alu_out),
        .exmem_v_alu_out(exmem_v_alu_out), .exmem_c_alu_out(exmem_c_alu_out),
        .exmem_z_flag_out(exmem_z_flag_out), .exmem_n_flag_out(exmem_n_flag_out),
        .exmem_v_flag_out(exmem_v_flag_out), .exmem_c_flag_out(exmem_c_flag_out)
    );

    function automatic int sel_width(input int sel);
        case (sel)
            0:                       return 32;
            1, 2, 3, 4, 5, 12, 13, 14: return 64;
            6, 7, 8, 10, 15, 17:     return 5;
            9:                       return 6;
            11, 16:                  return 2;
            default:                 return 1;
        endcase
    endfunction

    function automatic logic [63:0] sel_mask(input int sel);
        int w;
        w = sel_width(sel);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] pat_val(input int sel);
        return (64'h9E37_79B9_7F4A_7C15 * 64'(sel + 1)) | 64'h1;
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:  return {32'd0, ifid_instr_out};
            1:  return ifid_pc_out;
            2:  return idex_rd1_out;
            3:  return idex_rd2_out;
            4:  return idex_pc_out;
            5:  return idex_se_out;
            6:  return {59'd0, idex_rn_out};
            7:  return {59'd0, idex_rm_out};
            8:  return {59'd0, idex_rd_out};
            9:  return {58'd0, idex_ex_out};
            10: return {59'd0, idex_m_out};
            11: return {62'd0, idex_wb_out};
            12: return exmem_alu_out;
            13: return exmem_wdata_out;
            14: return exmem_addr_out;
            15: return {59'd0, exmem_rd_out};
            16: return {62'd0, exmem_wb_out};
            17: return {59'd0, exmem_m_out};
            18: return {63'd0, exmem_z_alu_out};
            19: return {63'd0, exmem_n_alu_out};
            20: return {63'd0, exmem_v_alu_out};
            21: return {63'd0, exmem_c_alu_out};
            22: return {63'd0, exmem_z_flag_out};
            23: return {63'd0, exmem_n_flag_out};
            24: return {63'd0, exmem_v_flag_out};
            default: return {63'd0, exmem_c_flag_out};
        endcase
    endfunction

    task automatic drive(input int sel, input logic [63:0] v);
        case (sel)
            0:  ifid_instr   = v[31:0];
            1:  ifid_pc      = v;
            2:  idex_rd1     = v;
            3:  idex_rd2     = v;
            4:  idex_pc      = v;
            5:  idex_se      = v;
            6:  idex_rn      = v[4:0];
            7:  idex_rm      = v[4:0];
            8:  idex_rd      = v[4:0];
            9:  idex_ex      = v[5:0];
            10: idex_m       = v[4:0];
            11: idex_wb      = v[1:0];
            12: exmem_alu    = v;
            13: exmem_wdata  = v;
            14: exmem_addr   = v;
            15: exmem_rd     = v[4:0];
            16: exmem_wb     = v[1:0];
            17: exmem_m      = v[4:0];
            18: exmem_z_alu  = v[0];
            19: exmem_n_alu  = v[0];
            20: exmem_v_alu  = v[0];
            21: exmem_c_alu  = v[0];
            22: exmem_z_flag = v[0];
            23: exmem_n_flag = v[0];
            24: exmem_v_flag = v[0];
            default: exmem_c_flag = v[0];
        endcase
    endtask

    task automatic push(input string tag, input int sel, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v & sel_mask(sel);
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input bit use_pattern);
        for (int i = 0; i < NSEL; i++) push(tag, i, use_pattern ? pat_val(i) : 64'd0);
    endtask

    task automatic check_sb();
        exp_t        e;
        logic [63:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            n_checks++;
            assert (obs === e.exp) else begin
                n_errors++;
                $error("FAIL %s sel=%0d observed=%h expected=%h", e.tag, e.sel, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        rst = 1'b0;
        ifid_en = 1'b1; idex_en = 1'b1; exmem_en = 1'b1;
        ifid_flush = 1'b0; idex_flush = 1'b0; exmem_flush = 1'b0;
        for (int i = 0; i < NSEL; i++) drive(i, 64'd0);
        #1;
        push_all("por_zero", 1'b0);
        check_sb();

        // Release reset mid-cycle; first capture must happen at the next rising edge.
        @(negedge clk); #2;
        rst = 1'b1;
        for (int i = 0; i < NSEL; i++) drive(i, pat_val(i));
        push_all("first_capture", 1'b1);
        tick();

        // Asynchronous reset with nonzero inputs: outputs clear before any edge.
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        push_all("async_reset", 1'b0);
        check_sb();
        push_all("reset_held", 1'b0);
        tick();

        @(negedge clk); #2;
        rst = 1'b1;
        drive(S_IFID_INSTR, 64'h8B02_0020);
        drive(S_IFID_PC,    64'h10);
        drive(S_IDEX_RD1,   64'hDEAD);
        drive(S_EXMEM_ALU,  64'h1234);
        #1;
        push("no_comb_instr", S_IFID_INSTR, 64'd0);
        push("no_comb_alu",   S_EXMEM_ALU,  64'd0);
        check_sb();
        push("pass_instr", S_IFID_INSTR, 64'h8B02_0020);
        push("pass_pc",    S_IFID_PC,    64'h10);
        push("pass_rd1",   S_IDEX_RD1,   64'hDEAD);
        push("pass_alu",   S_EXMEM_ALU,  64'h1234);
        tick();

        @(negedge clk);
        ifid_en = 1'b0;
        drive(S_IFID_INSTR, 64'hFFFF_FFFF);
        drive(S_IFID_PC,    64'h20);
        drive(S_IDEX_RD1,   64'hBEEF);
        drive(S_EXMEM_ALU,  64'h5678);
        push("stall_instr", S_IFID_INSTR, 64'h8B02_0020);
        push("stall_pc",    S_IFID_PC,    64'h10);
        push("upd_rd1",     S_IDEX_RD1,   64'hBEEF);
        push("upd_alu",     S_EXMEM_ALU,  64'h5678);
        tick();
        push("stall_instr2", S_IFID_INSTR, 64'h8B02_0020);
        tick();

        @(negedge clk);
        ifid_en = 1'b1;
        idex_flush = 1'b1;
        drive(S_IFID_INSTR, 64'hAAAA_5555);
        drive(S_IDEX_WB,  64'h2);
        drive(S_IDEX_M,   64'h02);
        drive(S_IDEX_EX,  64'h15);
        drive(S_IDEX_RD1, 64'h1111);
        drive(S_IDEX_RD,  64'h7);
        push("resume_instr", S_IFID_INSTR, 64'hAAAA_5555);
        push("flush_wb",  S_IDEX_WB,  64'd0);
        push("flush_m",   S_IDEX_M,   64'd0);
        push("flush_ex",  S_IDEX_EX,  64'd0);
        push("flush_rd1", S_IDEX_RD1, 64'd0);
        push("flush_rd",  S_IDEX_RD,  64'd0);
        push("flush_pc",  S_IDEX_PC,  64'd0);
        push("indep_alu", S_EXMEM_ALU, 64'h5678);
        tick();

        @(negedge clk);
        idex_flush = 1'b0;
        exmem_flush = 1'b1;
        drive(S_EXMEM_RD,  64'd9);
        drive(S_EXMEM_M,   64'h15);
        drive(S_EXMEM_ALU, 64'h9999);
        push("prio_rd",  S_EXMEM_RD,  64'd0);
        push("prio_m",   S_EXMEM_M,   64'd0);
        push("prio_wb",  S_EXMEM_WB,  64'd0);
        push("prio_alu", S_EXMEM_ALU, 64'd0);
        push("idex_wb",  S_IDEX_WB,   64'h2);
        push("idex_m",   S_IDEX_M,    64'h02);
        push("idex_rd1", S_IDEX_RD1,  64'h1111);
        tick();

        @(negedge clk);
        exmem_flush = 1'b0;
        ifid_flush = 1'b1;
        push("ifid_flush_instr", S_IFID_INSTR, 64'd0);
        push("ifid_flush_pc",    S_IFID_PC,    64'd0);
        push("exmem_rd_load",    S_EXMEM_RD,   64'd9);
        tick();

        @(negedge clk);
        ifid_flush = 1'b0;
        drive(S_N_FLAG, 64'd1);
        drive(S_V_FLAG, 64'd0);
        drive(S_Z_ALU,  64'd1);
        push("flag_n", S_N_FLAG, 64'd1);
        push("flag_v", S_V_FLAG, 64'd0);
        push("alu_z",  S_Z_ALU,  64'd1);
        tick();

        @(negedge clk);
        exmem_en = 1'b0;
        drive(S_N_FLAG, 64'd0);
        drive(S_V_FLAG, 64'd1);
        drive(S_Z_ALU,  64'd0);
        drive(S_EXMEM_RD, 64'd3);
        drive(S_IDEX_RD1, 64'h2222);
        push("hold_n",  S_N_FLAG,   64'd1);
        push("hold_v",  S_V_FLAG,   64'd0);
        push("hold_z",  S_Z_ALU,    64'd1);
        push("hold_rd", S_EXMEM_RD, 64'd9);
        push("idex_live_rd1", S_IDEX_RD1, 64'h2222);
        tick();
        push("hold_n2", S_N_FLAG, 64'd1);
        push("hold_z2", S_Z_ALU,  64'd1);
        tick();

        @(negedge clk);
        idex_en = 1'b0;
        exmem_en = 1'b1;
        drive(S_IDEX_RD1, 64'h3333);
        push("idex_stall_rd1", S_IDEX_RD1, 64'h2222);
        push("exmem_rd_new",   S_EXMEM_RD, 64'd3);
        push("flag_n_new",     S_N_FLAG,   64'd0);
        push("flag_v_new",     S_V_FLAG,   64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
